// File: rtl/instr_encoder_loader.sv
// Streaming RV32I instruction encoder: packs decoded fields into 32-bit words and writes them
// to instruction memory at consecutive word addresses through a one-entry output register.
module instr_encoder_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  full,
  output logic                  err
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;

  logic [31:0] enc;
  logic        legal;
  logic        accept;
  logic        commit;

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (fmt)
      FMT_R: enc = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: enc = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: enc = {imm[31:12], rd, opcode};
      FMT_J: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: legal = 1'b0;
    endcase
  end

  // rst_n gates in_ready so nothing is offered as accepted while reset is held.
  assign in_ready = rst_n & ~full_q & ~clear & (~we_q | mem_ready);
  assign accept   = in_valid & in_ready;
  assign commit   = we_q & mem_ready;

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    err_d   = err_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    if (clear) begin
      ptr_d  = '0;
      cnt_d  = '0;
      full_d = 1'b0;
      err_d  = 1'b0;
      we_d   = 1'b0;
    end else begin
      if (commit) begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        cnt_d = cnt_q + (ADDR_WIDTH + 1)'(1);
        we_d  = 1'b0;
        if (cnt_d == CAPACITY) full_d = 1'b1;
      end
      // Illegal bundles are consumed but only raise err.
      if (accept) begin
        if (legal) begin
          we_d    = 1'b1;
          wdata_d = enc;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = ptr_q;
  assign mem_wdata = wdata_q;
  assign wcount    = cnt_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: two instances (256 and 4 words) driven in lockstep and
// compared each cycle against a transaction-level model plus known RV32I encodings.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        mem_ready = 1'b1;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;

  logic        in_ready_a, mem_we_a, full_a, err_a;
  logic [7:0]  mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic [8:0]  wcount_a;
  logic        in_ready_b, mem_we_b, full_b, err_b;
  logic [1:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [2:0]  wcount_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_ready(mem_ready), .wcount(wcount_a), .full(full_a),
    .err(err_a)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_ready(mem_ready), .wcount(wcount_b), .full(full_b),
    .err(err_b)
  );

  // Observed outputs, widened so both instances share one set of checks.
  logic        o_rdy[2], o_we[2], o_full[2], o_err[2];
  logic [31:0] o_addr[2], o_data[2], o_cnt[2];
  always_comb begin
    o_rdy[0] = in_ready_a;  o_we[0] = mem_we_a;  o_full[0] = full_a;  o_err[0] = err_a;
    o_addr[0] = 32'(mem_addr_a); o_data[0] = mem_wdata_a; o_cnt[0] = 32'(wcount_a);
    o_rdy[1] = in_ready_b;  o_we[1] = mem_we_b;  o_full[1] = full_b;  o_err[1] = err_b;
    o_addr[1] = 32'(mem_addr_b); o_data[1] = mem_wdata_b; o_cnt[1] = 32'(wcount_b);
  end

  // Reference model state: committed count, one pending word, sticky flags.
  int          cap[2] = '{256, 4};
  int          m_cnt[2];
  bit          m_pend[2], m_full[2], m_err[2];
  logic [31:0] m_data[2];

  function automatic logic [31:0] ref_enc();
    logic [31:0] i = imm;
    logic [31:0] base = 32'(opcode);
    case (fmt)
      3'd0: return (32'(funct7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                   | (32'(funct3) << 12) | (32'(rd) << 7) | base;
      3'd1: return ((i & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(funct3) << 12)
                   | (32'(rd) << 7) | base;
      3'd2: return (((i >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                   | (32'(funct3) << 12) | ((i & 32'h1f) << 7) | base;
      3'd3: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3f) << 25)
                   | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(funct3) << 12)
                   | (((i >> 1) & 32'hf) << 8) | (((i >> 11) & 32'h1) << 7) | base;
      3'd4: return (i & 32'hfffff000) | (32'(rd) << 7) | base;
      default: return (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3ff) << 21)
                   | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hff) << 12)
                   | (32'(rd) << 7) | base;
    endcase
  endfunction

  function automatic bit exp_rdy(int k);
    return !m_full[k] && !clear && (!m_pend[k] || mem_ready);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pend[k] = 0; m_full[k] = 0; m_err[k] = 0; m_data[k] = '0;
    end
  endtask

  task automatic model_edge(int k);
    bit rdy = exp_rdy(k);
    if (clear) begin
      m_cnt[k] = 0; m_pend[k] = 0; m_full[k] = 0; m_err[k] = 0;
    end else begin
      if (m_pend[k] && mem_ready) begin
        m_cnt[k]++;
        m_pend[k] = 0;
        if (m_cnt[k] == cap[k]) m_full[k] = 1;
      end
      if (in_valid && rdy) begin
        if (fmt <= 3'd5) begin
          m_pend[k] = 1;
          m_data[k] = ref_enc();
        end else begin
          m_err[k] = 1;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mem_we[%0d]", k), 64'(o_we[k]), 64'(m_pend[k]));
      chk($sformatf("mem_addr[%0d]", k), 64'(o_addr[k]), 64'(m_cnt[k] % cap[k]));
      chk($sformatf("mem_wdata[%0d]", k), 64'(o_data[k]), 64'(m_data[k]));
      chk($sformatf("wcount[%0d]", k), 64'(o_cnt[k]), 64'(m_cnt[k]));
      chk($sformatf("full[%0d]", k), 64'(o_full[k]), 64'(m_full[k]));
      chk($sformatf("err[%0d]", k), 64'(o_err[k]), 64'(m_err[k]));
    end
  endtask

  // Inputs are set at a falling edge; this checks in_ready, clocks once, checks registers.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("in_ready[%0d]", k), 64'(o_rdy[k]),
                                    64'(exp_rdy(k)));
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    @(negedge clk);
    check_regs();
  endtask

  task automatic bundle(logic [2:0] f, logic [6:0] op, logic [4:0] d, logic [2:0] f3,
                        logic [4:0] s1, logic [4:0] s2, logic [6:0] f7, logic [31:0] im);
    in_valid = 1'b1; fmt = f; opcode = op; rd = d; funct3 = f3;
    rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic do_clear();
    in_valid = 1'b0; clear = 1'b1; mem_ready = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic seq_word(int n);
    bundle(3'd1, 7'h13, 5'(n + 1), 3'd0, 5'd0, 5'd0, 7'd0, 32'(n));
  endtask

  logic [31:0] known[6] = '{32'h00500093, 32'h002081B3, 32'h0020A423,
                            32'h00208463, 32'h123452B7, 32'h010000EF};
  logic [31:0] held;

  initial begin
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) chk($sformatf("rst in_ready[%0d]", k), 64'(o_rdy[k]), 64'd0);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    check_regs();

    // Six reference instructions back-to-back.
    mem_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      case (n)
        0: bundle(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        1: bundle(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
        2: bundle(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
        3: bundle(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8);
        4: bundle(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
        default: bundle(3'd5, 7'h6f, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd16);
      endcase
      step();
      chk("known word", 64'(mem_wdata_a), 64'(known[n]));
      chk("known addr", 64'(mem_addr_a), 64'(n));
    end
    idle(2);
    chk("six wcount", 64'(wcount_a), 64'd6);

    // Fill the 4-word instance exactly, then clear and restart.
    do_clear();
    for (int n = 0; n < 4; n++) begin seq_word(n); step(); end
    idle(2);
    chk("cap full", 64'(full_b), 64'd1);
    chk("cap in_ready", 64'(in_ready_b), 64'd0);
    chk("cap addr", 64'(mem_addr_b), 64'd0);
    chk("cap wcount", 64'(wcount_b), 64'd4);
    do_clear();
    chk("clr full", 64'(full_b), 64'd0);
    chk("clr wcount", 64'(wcount_b), 64'd0);
    seq_word(9); step();
    chk("restart addr", 64'(mem_addr_b), 64'd0);
    chk("restart we", 64'(mem_we_b), 64'd1);
    idle(1);

    // Backpressure for three cycles with a bundle waiting.
    do_clear();
    seq_word(0); step();
    held = mem_wdata_a;
    mem_ready = 1'b0; seq_word(1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp hold data", 64'(mem_wdata_a), 64'(held));
      chk("bp hold addr", 64'(mem_addr_a), 64'd0);
      chk("bp in_ready", 64'(in_ready_a), 64'd0);
    end
    mem_ready = 1'b1; step();
    chk("bp commit", 64'(wcount_a), 64'd1);
    chk("bp next addr", 64'(mem_addr_a), 64'd1);
    idle(2);

    // Illegal format between two legal bundles.
    do_clear();
    seq_word(0); step();
    bundle(3'd6, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0); step();
    seq_word(2); step();
    chk("ill addr", 64'(mem_addr_a), 64'd1);
    idle(2);
    chk("ill err", 64'(err_a), 64'd1);
    chk("ill wcount", 64'(wcount_a), 64'd2);

    // Clear while a write is stalled.
    do_clear();
    seq_word(0); mem_ready = 1'b0; step();
    in_valid = 1'b0; clear = 1'b1; step();
    clear = 1'b0;
    chk("clr pend we", 64'(mem_we_a), 64'd0);
    chk("clr pend wcount", 64'(wcount_a), 64'd0);
    mem_ready = 1'b1;

    // Asynchronous reset in the middle of a stream.
    for (int n = 0; n < 3; n++) begin seq_word(n); step(); end
    #3 rst_n = 1'b0;
    #1;
    chk("arst we", 64'(mem_we_a), 64'd0);
    chk("arst wcount", 64'(wcount_a), 64'd0);
    chk("arst in_ready", 64'(in_ready_a), 64'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    seq_word(7); step();
    chk("arst restart addr", 64'(mem_addr_a), 64'd0);
    idle(1);

    // Randomized traffic with occasional clears and illegal formats.
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom % 4) != 0;
      mem_ready = ($urandom % 4) != 0;
      clear     = ($urandom % 50) == 0;
      fmt       = ($urandom % 10 == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom % 6);
      opcode    = 7'($urandom); rd = 5'($urandom); funct3 = 3'($urandom);
      rs1       = 5'($urandom); rs2 = 5'($urandom); funct7 = 7'($urandom);
      imm       = $urandom;
      step();
    end
    clear = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Streaming RISC-V instruction encoder. Takes decoded instruction fields (opcode, rd, funct3, rs1, rs2, funct7, immediate) plus a format selector and packs them into 32-bit RV32I words. It writes the words into instruction memory at consecutive word addresses over a valid/ready handshake. It sits ahead of the pipeline's instruction memory as the program loader and is the inverse of the fetch-side field parser.

## Interface
- ADDR_WIDTH, 8, word-address width; capacity is 2^ADDR_WIDTH words
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- clear  in  1  synchronous restart: write pointer to 0, flags cleared
- in_valid  in  1  field bundle valid
- in_ready  out  1  block accepts the bundle this cycle
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- opcode  in  7 / rd  in  5 / funct3  in  3 / rs1  in  5 / rs2  in  5 / funct7  in  7  instruction fields
- imm  in  32  immediate, byte-offset semantics as in the ISA
- mem_we  out  1  write request to instruction memory
- mem_addr  out  ADDR_WIDTH  word address of the pending write
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts the write this cycle
- wcount  out  ADDR_WIDTH+1  words committed since reset/clear
- full  out  1  capacity reached; sticky until clear/reset
- err  out  1  illegal fmt seen; sticky until clear/reset

## Operation
- Encoding is combinational from the inputs and is captured into the output register on acceptance (in_valid & in_ready). Fields a format does not use are ignored.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; imm[0] is ignored
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; imm[0] is ignored
- Illegal fmt:
  - The bundle is accepted and consumed.
  - Nothing is written and the pointer does not advance.
  - err sets on the following edge.
- Output register: one entry holding mem_we, mem_addr and mem_wdata.
  - mem_we=1 while the entry is pending.
  - Outputs are held stable until mem_ready=1.
  - A write commits on mem_we & mem_ready. The pointer and wcount then increment by 1.
- in_ready = !full & !clear & (!mem_we | mem_ready). This allows back-to-back acceptance, one word per cycle, when memory is always ready.
- mem_addr equals the write pointer, which is the count of committed words modulo 2^ADDR_WIDTH.
- full sets on the commit that brings wcount to 2^ADDR_WIDTH. The pointer wraps to 0, but no further bundles are accepted until clear.
- clear has priority over all other events in its cycle:
  - pointer, wcount, full and err go to 0
  - any pending write is dropped, so mem_we=0 next cycle
  - a commit in the same cycle is not counted

## Timing
- Reset values: in_ready=0 during reset and 1 on the first cycle after deassertion; mem_we=0, mem_addr=0, mem_wdata=0, wcount=0, full=0, err=0.
- Latency: bundle accepted at edge N, so mem_we=1 with data and address valid after edge N. The earliest commit is edge N+1.
- Throughput: 1 word/cycle with mem_ready tied high.
- Stall: with mem_ready=0, in_ready=0 and the output register holds. A new bundle is accepted in the same cycle the stalled entry commits.
- Asynchronous reset mid-transfer: the pending write is discarded immediately and all outputs go to their reset values without waiting for clk.

## Test plan
- Reset, then six bundles with mem_ready=1:
  - I addi x1,x0,5 -> 0x00500093
  - R add x3,x1,x2 -> 0x002081B3
  - S sw x2,8(x1) -> 0x0020A423
  - B beq x1,x2,+8 -> 0x00208463
  - U lui x5,0x12345 -> 0x123452B7
  - J jal x1,+16 -> 0x010000EF
  - Required: addresses 0..5 on consecutive cycles; wcount=6.
- Backpressure: hold mem_ready=0 for 3 cycles with in_valid=1. Required: mem_wdata and mem_addr stable, in_ready=0; one commit on release; the next bundle is accepted in that cycle.
- Illegal fmt=6 between two legal bundles. Required: err=1; the second legal word lands at address 1; wcount=2.
- ADDR_WIDTH=2: write 4 words. Required: full=1 after the 4th commit, in_ready=0, mem_addr=0. Then assert clear. Required: full=0, wcount=0, and the next word lands at address 0.
- clear asserted while a write is pending with mem_ready=0. Required: mem_we=0 next cycle and wcount=0.
- rst_n pulsed low mid-stream, asynchronous to clk. Required: mem_we=0 and wcount=0 immediately; the stream restarts at address 0.
